// File: rtl/conv_patch_addr_gen.sv
// Window position tracker and K-row read-burst address generator for a KxK
// sliding-window convolution over an IMG_H x IMG_W feature map.
module conv_patch_addr_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 10,
    localparam int OUT_W   = (IMG_W - K) / STRIDE + 1,
    localparam int OUT_H   = (IMG_H - K) / STRIDE + 1,
    localparam int OUT_MAX = (OUT_W > OUT_H) ? OUT_W : OUT_H,
    localparam int CW      = (OUT_MAX > 1) ? $clog2(OUT_MAX) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_req,
    input  logic              counter_enable,
    input  logic              restart,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CW-1:0]     patch_row,
    output logic [CW-1:0]     patch_col,
    output logic              done
);

    localparam int BW = (K > 1) ? $clog2(K) : 1;
    localparam logic [ADDR_W-1:0] ROW_PITCH    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] WIN_ROW_STEP = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] WIN_COL_STEP = ADDR_W'(STRIDE);
    localparam logic [CW-1:0]     LAST_COL     = CW'(OUT_W - 1);
    localparam logic [CW-1:0]     LAST_ROW     = CW'(OUT_H - 1);
    localparam logic [BW-1:0]     LAST_BEAT    = BW'(K - 1);

    // The whole map must be addressable, otherwise base/rd_addr would wrap.
    if (IMG_W * IMG_H > 2 ** ADDR_W) begin : g_addr_range_check
        $error("conv_patch_addr_gen: IMG_W*IMG_H exceeds 2**ADDR_W");
    end

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    state_e            state_q;
    logic [BW-1:0]     beat_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_valid_q;
    logic [CW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] base_d;

    // On the final patch the position holds and only done rises.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        wr_d   = wr_q;
        done_d = done_q;
        base_d = ADDR_W'(row_q) * WIN_ROW_STEP + ADDR_W'(col_q) * WIN_COL_STEP;
        if (counter_enable && !done_q) begin
            if (col_q == LAST_COL) begin
                if (row_q == LAST_ROW) begin
                    done_d = 1'b1;
                end else begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                    wr_d  = wr_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
                wr_d  = wr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            row_q  <= '0;
            col_q  <= '0;
            wr_q   <= '0;
            done_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            wr_q   <= wr_d;
            done_q <= done_d;
        end
    end

    // base_d is taken from the pre-increment position, so a burst requested
    // together with counter_enable still fetches the current patch.
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (addr_req && !done_q) begin
                        state_q    <= BURST;
                        beat_q     <= '0;
                        rd_addr_q  <= base_d;
                        rd_valid_q <= 1'b1;
                    end
                end
                BURST: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q    <= IDLE;
                        beat_q     <= '0;
                        rd_addr_q  <= '0;
                        rd_valid_q <= 1'b0;
                    end else begin
                        beat_q    <= beat_q + 1'b1;
                        rd_addr_q <= rd_addr_q + ROW_PITCH;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    beat_q     <= '0;
                    rd_addr_q  <= '0;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr   = rd_addr_q;
    assign rd_valid  = rd_valid_q;
    assign wr_addr   = wr_q;
    assign patch_row = row_q;
    assign patch_col = col_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_patch_addr_gen.sv
// Bench for conv_patch_addr_gen: directed scenarios on a 5x5/K3/S1 map, a
// 7x7/K3/S2 stride check, and a random run against a patch-index model.
module tb_conv_patch_addr_gen;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int KK = 3;
    localparam int S  = 1;
    localparam int OW = (W - KK) / S + 1;
    localparam int OH = (H - KK) / S + 1;

    localparam int W2  = 7;
    localparam int S2  = 2;
    localparam int OW2 = (W2 - KK) / S2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, addr_req, counter_enable, restart;
    logic [9:0] rd_addr, wr_addr;
    logic       rd_valid, done;
    logic [1:0] patch_row, patch_col;

    logic       rst_n2, addr_req2, counter_enable2, restart2;
    logic [9:0] rd_addr2, wr_addr2;
    logic       rd_valid2, done2;
    logic [1:0] patch_row2, patch_col2;

    int total = 0;
    int bad   = 0;

    // Reference model: patch index, sticky done, queue of pending burst addresses.
    int m_idx   = 0;
    bit m_done  = 1'b0;
    bit m_valid = 1'b0;
    int m_addr  = 0;
    int m_q[$];

    conv_patch_addr_gen #(.IMG_W(W), .IMG_H(H), .K(KK), .STRIDE(S), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .addr_req(addr_req), .counter_enable(counter_enable),
        .restart(restart), .rd_addr(rd_addr), .rd_valid(rd_valid), .wr_addr(wr_addr),
        .patch_row(patch_row), .patch_col(patch_col), .done(done)
    );

    conv_patch_addr_gen #(.IMG_W(W2), .IMG_H(W2), .K(KK), .STRIDE(S2), .ADDR_W(10)) dut2 (
        .clk(clk), .rst_n(rst_n2), .addr_req(addr_req2), .counter_enable(counter_enable2),
        .restart(restart2), .rd_addr(rd_addr2), .rd_valid(rd_valid2), .wr_addr(wr_addr2),
        .patch_row(patch_row2), .patch_col(patch_col2), .done(done2)
    );

    // Drive one cycle of inputs on dut, advance the model across the edge, settle #1.
    task automatic step(input bit rn, input bit ar, input bit ce, input bit rs);
        int base;
        rst_n = rn; addr_req = ar; counter_enable = ce; restart = rs;
        @(posedge clk);
        if (!rn || rs) begin
            m_idx = 0; m_done = 1'b0; m_valid = 1'b0; m_addr = 0;
            m_q.delete();
        end else begin
            if (ar && !m_valid && !m_done) begin
                base = (m_idx / OW) * S * W + (m_idx % OW) * S;
                for (int b = 0; b < KK; b++) m_q.push_back(base + b * W);
            end
            if (ce && !m_done) begin
                if (m_idx == OW * OH - 1) m_done = 1'b1;
                else m_idx++;
            end
            if (m_q.size() > 0) begin
                m_valid = 1'b1;
                m_addr  = m_q.pop_front();
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_valid: got %0d want 0", rd_valid); end
        total++; if (rd_addr !== 10'd0) begin bad++; $display("[TB] FAIL reset_rd_addr: got %0d want 0", rd_addr); end
        total++; if (wr_addr !== 10'd0) begin bad++; $display("[TB] FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        total++; if (patch_row !== 2'd0 || patch_col !== 2'd0) begin bad++; $display("[TB] FAIL reset_pos: got %0d,%0d want 0,0", patch_row, patch_col); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %0d want 0", done); end
        step(1, 0, 0, 0);
        total++; if (done !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset: got done=%0d valid=%0d want 0,0", done, rd_valid); end
    endtask

    task automatic test_burst_origin();
        int exp_a[3] = '{0, 5, 10};
        step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd_valid !== 1'b1 || rd_addr !== exp_a[i]) begin
                bad++; $display("[TB] FAIL origin_beat%0d: got valid=%0d addr=%0d want 1,%0d", i, rd_valid, rd_addr, exp_a[i]);
            end
            if (i < 2) step(1, 1, 0, 0);
        end
        step(1, 0, 0, 0);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL origin_end: got valid=%0d want 0", rd_valid); end
    endtask

    task automatic test_advance_and_burst();
        int exp_a[3] = '{6, 11, 16};
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
        total++;
        if (patch_row !== 2'd1 || patch_col !== 2'd1 || wr_addr !== 10'd4) begin
            bad++; $display("[TB] FAIL advance_pos: got row=%0d col=%0d wr=%0d want 1,1,4", patch_row, patch_col, wr_addr);
        end
        step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd_valid !== 1'b1 || rd_addr !== exp_a[i]) begin
                bad++; $display("[TB] FAIL advance_beat%0d: got valid=%0d addr=%0d want 1,%0d", i, rd_valid, rd_addr, exp_a[i]);
            end
            step(1, 0, 0, 0);
        end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL advance_end: got valid=%0d want 0", rd_valid); end
    endtask

    task automatic test_done();
        step(1, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 1, 0);
            if (i == 7) begin
                total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL done_early: got %0d want 0", done); end
            end
        end
        total++;
        if (done !== 1'b1 || wr_addr !== 10'd8 || patch_row !== 2'd2 || patch_col !== 2'd2) begin
            bad++; $display("[TB] FAIL done_set: got done=%0d wr=%0d row=%0d col=%0d want 1,8,2,2", done, wr_addr, patch_row, patch_col);
        end
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        total++;
        if (done !== 1'b1 || wr_addr !== 10'd8 || patch_row !== 2'd2 || patch_col !== 2'd2 || rd_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL done_hold: got done=%0d wr=%0d row=%0d col=%0d valid=%0d want 1,8,2,2,0", done, wr_addr, patch_row, patch_col, rd_valid);
        end
    endtask

    task automatic test_restart_done();
        step(1, 0, 1, 1);
        total++;
        if (done !== 1'b0 || wr_addr !== 10'd0 || patch_row !== 2'd0 || patch_col !== 2'd0) begin
            bad++; $display("[TB] FAIL restart: got done=%0d wr=%0d row=%0d col=%0d want 0,0,0,0", done, wr_addr, patch_row, patch_col);
        end
    endtask

    task automatic test_reset_mid_burst();
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        total++; if (rd_valid !== 1'b1 || rd_addr !== 10'd5) begin bad++; $display("[TB] FAIL midburst_beat1: got valid=%0d addr=%0d want 1,5", rd_valid, rd_addr); end
        step(0, 0, 0, 0);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL midburst_abort: got valid=%0d want 0", rd_valid); end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL midburst_tail%0d: got valid=%0d addr=%0d want 0", i, rd_valid, rd_addr); end
        end
    endtask

    task automatic test_stride2();
        int exp_a[3] = '{18, 25, 32};
        rst_n2 = 1'b0; addr_req2 = 1'b0; counter_enable2 = 1'b0; restart2 = 1'b0;
        @(posedge clk); #1;
        rst_n2 = 1'b1; counter_enable2 = 1'b1;
        for (int i = 0; i < OW2 + 2; i++) begin
            @(posedge clk); #1;
        end
        counter_enable2 = 1'b0;
        total++;
        if (patch_row2 !== 2'd1 || patch_col2 !== 2'd2 || wr_addr2 !== 10'd5) begin
            bad++; $display("[TB] FAIL stride2_pos: got row=%0d col=%0d wr=%0d want 1,2,5", patch_row2, patch_col2, wr_addr2);
        end
        addr_req2 = 1'b1;
        @(posedge clk); #1;
        addr_req2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd_valid2 !== 1'b1 || rd_addr2 !== exp_a[i]) begin
                bad++; $display("[TB] FAIL stride2_beat%0d: got valid=%0d addr=%0d want 1,%0d", i, rd_valid2, rd_addr2, exp_a[i]);
            end
            @(posedge clk); #1;
        end
        total++; if (rd_valid2 !== 1'b0) begin bad++; $display("[TB] FAIL stride2_end: got valid=%0d want 0", rd_valid2); end
    endtask

    task automatic test_random();
        bit rn, ar, ce, rs;
        int errs_here;
        step(1, 0, 0, 1);
        for (int c = 0; c < 400; c++) begin
            rn = ($urandom_range(0, 99) != 0);
            ar = ($urandom_range(0, 99) < 30);
            ce = ($urandom_range(0, 99) < 25);
            rs = ($urandom_range(0, 99) < 2);
            step(rn, ar, ce, rs);
            errs_here = 0;
            if (rd_valid !== m_valid) errs_here++;
            if (m_valid && rd_addr !== m_addr) errs_here++;
            if (wr_addr !== m_idx) errs_here++;
            if (patch_row !== m_idx / OW || patch_col !== m_idx % OW) errs_here++;
            if (done !== m_done) errs_here++;
            total++;
            if (errs_here != 0) begin
                bad++;
                $display("[TB] FAIL random_c%0d: got v=%0d a=%0d wr=%0d r=%0d c=%0d d=%0d want v=%0d a=%0d wr=%0d r=%0d c=%0d d=%0d",
                         c, rd_valid, rd_addr, wr_addr, patch_row, patch_col, done,
                         m_valid, m_addr, m_idx, m_idx / OW, m_idx % OW, m_done);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; addr_req = 1'b0; counter_enable = 1'b0; restart = 1'b0;
        rst_n2 = 1'b0; addr_req2 = 1'b0; counter_enable2 = 1'b0; restart2 = 1'b0;
        test_reset();
        test_burst_origin();
        test_advance_and_burst();
        test_done();
        test_restart_done();
        test_reset_mid_burst();
        test_stride2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
